// File: rtl/pipe_sink_stage.sv
// -----------------------------------------------------------------------------
// pipe_sink_stage
//
// Terminal consumer of the valid/stall pipeline chain. Accepted words land in
// a small FIFO that is drained by a timer, one word every DRAIN_INTERVAL
// enabled cycles. Every accepted word is also checked against the previous
// accepted word plus one, because each upstream stage adds 1. Mismatches are
// counted so a test can observe them.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        synchronous active-low reset
//   i_flush        synchronous flush of FIFO, drain timer and sequence tracker
//   i_data/i_valid word from the previous stage
//   o_stall        back-pressure to the previous stage
//   o_current_ce   stage enable, always ~o_stall
//   i_drain_en     enables the timed drain
//   o_rd_data      last drained word (registered)
//   o_rd_valid     one-cycle pulse per drained word
//   o_level        FIFO occupancy
//   o_seq_err_cnt  saturating count of sequence mismatches
//   o_overflow     sticky: a valid word was dropped because the FIFO was full
//
// Build option:
//   PIPE_SINK_STALL_REG_EN  registered stall, asserted when the next-cycle
//                           level will be >= DEPTH-2. Undefined (default):
//                           combinational stall when level >= DEPTH-1.
// -----------------------------------------------------------------------------
module pipe_sink_stage #(
    parameter int DATA_W         = 16,
    parameter int DEPTH          = 4,
    parameter int DRAIN_INTERVAL = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_valid,
    output logic                   o_stall,
    output logic                   o_current_ce,
    input  logic                   i_drain_en,
    output logic [DATA_W-1:0]      o_rd_data,
    output logic                   o_rd_valid,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [7:0]             o_seq_err_cnt,
    output logic                   o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMR_W = (DRAIN_INTERVAL > 1) ? $clog2(DRAIN_INTERVAL) : 1;

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(DRAIN_INTERVAL - 1);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);

    typedef enum logic {
        SEQ_IDLE,
        SEQ_TRACK
    } seqState_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wrPtr_q,    wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q,    rdPtr_d;
    logic [LVL_W-1:0]  level_q,    level_d;
    logic [TMR_W-1:0]  timer_q,    timer_d;
    logic [DATA_W-1:0] rdData_q,   rdData_d;
    logic              rdValid_q,  rdValid_d;
    seqState_t         seqState_q, seqState_d;
    logic [DATA_W-1:0] expData_q,  expData_d;
    logic [7:0]        errCnt_q,   errCnt_d;
    logic              overflow_q, overflow_d;

    logic timerRun;
    logic popEn;
    logic pushEn;

    // Next-state logic. A pop frees a slot in the same cycle, so a full FIFO
    // that is popping still accepts an incoming word. Flush wins over all
    // normal activity but leaves the error count and overflow flag intact.
    always_comb begin
        timerRun   = i_drain_en && (level_q != '0);
        popEn      = timerRun && (timer_q == '0) && !i_flush;
        pushEn     = i_valid && !i_flush && ((level_q != LVL_FULL) || popEn);

        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        timer_d    = timer_q;
        rdData_d   = rdData_q;
        rdValid_d  = 1'b0;
        seqState_d = seqState_q;
        expData_d  = expData_q;
        errCnt_d   = errCnt_q;
        overflow_d = overflow_q;

        if (i_flush) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            level_d    = '0;
            timer_d    = TMR_RELOAD;
            seqState_d = SEQ_IDLE;
        end else begin
            if (pushEn) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (popEn) begin
                rdPtr_d  = rdPtr_q + PTR_W'(1);
                rdData_d = mem[rdPtr_q];
            end
            rdValid_d = popEn;

            case ({pushEn, popEn})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase

            // The timer only advances while there is something to drain.
            if (timerRun) begin
                timer_d = (timer_q == '0) ? TMR_RELOAD : timer_q - TMR_W'(1);
            end

            if (i_valid && !pushEn) begin
                overflow_d = 1'b1;
            end

            // Resync on every accepted word so a single bad word costs one
            // error rather than a run of them.
            if (pushEn) begin
                if ((seqState_q == SEQ_TRACK) && (i_data != expData_q) &&
                    (errCnt_q != 8'hFF)) begin
                    errCnt_d = errCnt_q + 8'd1;
                end
                expData_d  = i_data + DATA_W'(1);
                seqState_d = SEQ_TRACK;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            timer_q    <= TMR_RELOAD;
            rdData_q   <= '0;
            rdValid_q  <= 1'b0;
            seqState_q <= SEQ_IDLE;
            expData_q  <= '0;
            errCnt_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            timer_q    <= timer_d;
            rdData_q   <= rdData_d;
            rdValid_q  <= rdValid_d;
            seqState_q <= seqState_d;
            expData_q  <= expData_d;
            errCnt_q   <= errCnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; the pointers and level define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && pushEn) begin
            mem[wrPtr_q] <= i_data;
        end
    end

`ifdef PIPE_SINK_STALL_REG_EN
    logic stall_q;

    // Registered stall reacts one cycle late, so it looks at the upcoming
    // level and keeps two slots of slack instead of one.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= (level_d >= LVL_W'(DEPTH - 2));
        end
    end

    assign o_stall = stall_q;
`else
    assign o_stall = (level_q >= LVL_W'(DEPTH - 1));
`endif

    assign o_current_ce  = ~o_stall;
    assign o_rd_data     = rdData_q;
    assign o_rd_valid    = rdValid_q;
    assign o_level       = level_q;
    assign o_seq_err_cnt = errCnt_q;
    assign o_overflow    = overflow_q;

endmodule

// File: doc/pipe_sink_stage.md
Name: pipe_sink_stage

Overview:
Terminal consumer for the valid/stall pipeline chain. It accepts words from the last pipeline stage and buffers them in a small FIFO. It asserts stall back upstream when nearly full and drains one word every DRAIN_INTERVAL cycles. It also checks that accepted data increments by one per word, since each upstream stage adds 1, and counts violations for test visibility.

Parameters:
DATA_W, 16, width of data words
DEPTH, 4, FIFO entries; power of 2, >= 4
DRAIN_INTERVAL, 3, cycles between drain pops; >= 1

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, synchronous, active-low
i_flush  in  1  synchronous flush of FIFO and sequence tracker
i_data  in  DATA_W  data from previous stage
i_valid  in  1  i_data valid this cycle
o_stall  out  1  stall to previous stage (!ready)
o_current_ce  out  1  this stage enabled; equals ~o_stall
i_drain_en  in  1  enables timed draining
o_rd_data  out  DATA_W  drained word, registered
o_rd_valid  out  1  one-cycle pulse per drained word
o_level  out  log2(DEPTH)+1  current FIFO occupancy
o_seq_err_cnt  out  8  sequence mismatch count, saturating at 255
o_overflow  out  1  sticky: a valid word arrived while full and was dropped

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - FIFO empty, o_level=0, o_rd_data=0, o_rd_valid=0.
  - o_seq_err_cnt=0, o_overflow=0, tracker in IDLE, drain timer=DRAIN_INTERVAL-1.
  - o_stall=0, o_current_ce=1 once reset is released.
- Priority: reset > flush > normal operation.
- Stall, default build: o_stall = (o_level >= DEPTH-1), combinational from the registered level. This leaves one slot of slack for a word already in flight.
- Push: i_valid=1 and level<DEPTH writes i_data at the write pointer; the pointer wraps modulo DEPTH.
  - i_valid=1 at level==DEPTH: word dropped, o_overflow set until reset. Flush does not clear it.
  - A word is accepted whenever there is space, even while o_stall=1.
- Drain timer:
  - Decrements each cycle while i_drain_en=1 and FIFO non-empty.
  - At 0 it pops the head word, drives o_rd_data=head and o_rd_valid=1 on the next edge, and reloads to DRAIN_INTERVAL-1.
  - i_drain_en=0 or FIFO empty: timer holds its value, no pop.
  - DRAIN_INTERVAL=1: pops every cycle while non-empty.
- Push and pop in the same cycle: level unchanged. A pop from a full FIFO with a push that cycle accepts the push (no drop).
- Latency: a word pushed into an empty FIFO can appear on o_rd_data no earlier than the following cycle, subject to the timer.
- Sequence tracker FSM, evaluated on accepted pushes only:
  - IDLE: on accept, store exp = i_data+1 (mod 2^DATA_W) and go to TRACK.
  - TRACK: on accept, if i_data != exp increment o_seq_err_cnt (saturating at 255). In both cases set exp = i_data+1, so resync happens after a mismatch.
  - Wrap: 16'hFFFF followed by 16'h0000 is legal.
  - Dropped (overflow) words are not checked.
- Flush:
  - Empties the FIFO, zeros pointers and o_level, clears o_rd_valid, returns the tracker to IDLE and reloads the timer.
  - A push in the flush cycle is discarded.
  - o_seq_err_cnt and o_overflow are preserved.

Optional Feature:
PIPE_SINK_STALL_REG_EN
- Defined: o_stall is a flop, set when the next-cycle level will be >= DEPTH-2. This gives two slots of slack for the extra cycle of stall latency and keeps o_current_ce = ~o_stall. With a compliant upstream, the registered stall never drops a word.
- Undefined: combinational stall with threshold DEPTH-1, as described above.

Test Plan:
- Reset, then push 16'h0001..16'h0004 on consecutive cycles with i_drain_en=0 -> o_level reaches 3 and o_stall=1 from level 3; the 4th word is accepted (level 4); o_overflow=0; o_seq_err_cnt=0.
- From full, push a 5th word 16'h0005 -> word dropped, o_overflow=1, o_level stays 4; then i_drain_en=1 -> o_rd_data 1,2,3,4 with o_rd_valid pulses exactly 3 cycles apart.
- Push 16'hFFFE, 16'hFFFF, 16'h0000 -> o_seq_err_cnt stays 0. Then push 16'h0005 -> count becomes 1. Then push 16'h0006 -> count stays 1.
- With DRAIN_INTERVAL=1, push every cycle with i_valid=1 while draining -> o_level stays at 1, no stall, no drop over 100 words.
- Assert i_flush with level 3 and i_valid=1 in the same cycle -> next cycle o_level=0, o_rd_valid=0, o_stall=0, error count and o_overflow unchanged. Next push 16'h0100 is not flagged as an error.
- Assert i_rst_n=0 for one cycle mid-drain -> all outputs return to their reset values at that edge; no o_rd_valid pulse afterwards until new pushes arrive.
